// File: rtl/uart_pkg.sv
// Shared UART timing constants and the feeder FSM encoding.
package uart_pkg;

  localparam int unsigned CLK_HZ     = 50_000_000;
  localparam int unsigned BAUD       = 9600;
  // Round up so a bit-time never comes out shorter than the line needs.
  localparam int unsigned BIT_CYCLES = (CLK_HZ + BAUD - 1) / BAUD;
  // Start + 8 data + stop + one guard bit.
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned FRAME_CYCLES_DEF = FRAME_BITS * BIT_CYCLES;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO: register array, wrapping pointers and a separate occupancy count.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push;
  logic              w_pop;

  // Full/empty come from the pre-edge count, so a pop never frees room for a same-cycle push.
  always_comb begin
    full_o  = (r_count == (ADDR_W + 1)'(DEPTH));
    empty_o = (r_count == '0);
    w_push  = push_i && !full_o;
    w_pop   = pop_i && !empty_o;
    rdata_o = r_mem[r_rd_ptr];
    level_o = r_count;
  end

  // Storage write; contents are don't-care after reset because count gates reads.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata_i;
    end
  end

  // Pointers wrap naturally at DEPTH; count moves only on an unpaired push or pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and releases one per UART frame, pacing with a local frame timer.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int unsigned TIMER_W      = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_en_i,
  input  logic            clr_ovf_i,
  output logic            full_o,
  output logic            empty_o,
  output logic [ADDR_W:0] level_o,
  output logic            overflow_o,
  output logic            busy_o,
  output logic [7:0]      uart_tx_data_o,
  output logic            uart_tx_en_o
);

  feeder_state_e      r_state;
  feeder_state_e      w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [7:0]         r_tx_data;
  logic [7:0]         w_tx_data_nxt;
  logic               r_tx_en;
  logic               w_tx_en_nxt;
  logic               r_overflow;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [7:0]         w_rdata;
  logic [ADDR_W:0]    w_level;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (wr_en_i),
    .wdata_i (wr_data_i),
    .pop_i   (w_pop),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // Next-state: pop and launch a frame from IDLE, then hold off until the timer expires.
  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_tx_data_nxt = r_tx_data;
    w_tx_en_nxt   = 1'b0;
    w_pop         = 1'b0;
    case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_tx_data_nxt = w_rdata;
          w_tx_en_nxt   = 1'b1;
          w_timer_nxt   = '0;
          w_state_nxt   = StWait;
        end
      end
      StWait: begin
        if (r_timer == TIMER_W'(FRAME_CYCLES - 1)) begin
          w_state_nxt = StIdle;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM, timer and registered transmitter interface.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= StIdle;
      r_timer   <= '0;
      r_tx_data <= 8'h00;
      r_tx_en   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_en   <= w_tx_en_nxt;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_overflow <= 1'b0;
    end else if (wr_en_i && w_full) begin
      r_overflow <= 1'b1;
    end else if (clr_ovf_i) begin
      r_overflow <= 1'b0;
    end
  end

  // Output map.
  always_comb begin
    full_o         = w_full;
    empty_o        = w_empty;
    level_o        = w_level;
    overflow_o     = r_overflow;
    busy_o         = (r_state != StIdle);
    uart_tx_data_o = r_tx_data;
    uart_tx_en_o   = r_tx_en;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed scoreboard bench for uart_tx_feeder with a shortened frame.
module tb_uart_tx_feeder;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned F       = 40;
  localparam int unsigned TIMER_W = 16;

  logic            clk_i = 1'b0;
  logic            rst_n_i;
  logic [7:0]      wr_data_i;
  logic            wr_en_i;
  logic            clr_ovf_i;
  logic            full_o;
  logic            empty_o;
  logic [ADDR_W:0] level_o;
  logic            overflow_o;
  logic            busy_o;
  logic [7:0]      uart_tx_data_o;
  logic            uart_tx_en_o;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         en_cnt = 0;
  logic       prev_en = 1'b0;
  logic [7:0] sb[$];
  int         en_cyc[$];

  uart_tx_feeder #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .FRAME_CYCLES (F),
    .TIMER_W      (TIMER_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .wr_data_i      (wr_data_i),
    .wr_en_i        (wr_en_i),
    .clr_ovf_i      (clr_ovf_i),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .level_o        (level_o),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o),
    .uart_tx_data_o (uart_tx_data_o),
    .uart_tx_en_o   (uart_tx_en_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every en pulse pops the scoreboard; en must never repeat on adjacent cycles.
  always @(negedge clk_i) begin
    logic [7:0] exp_b;
    if (uart_tx_en_o === 1'b1) begin
      en_cnt++;
      en_cyc.push_back(cyc);
      check("en_consecutive", 32'(prev_en), 32'd0);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_en: observed data %0h expected no pulse", uart_tx_data_o);
      end
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("tx_data", 32'(uart_tx_data_o), 32'(exp_b));
      end
    end
    prev_en = uart_tx_en_o;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_data_i = b;
    wr_en_i   = 1'b1;
    tick();
    wr_en_i   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n = 0;
    while (!(empty_o && !busy_o) && n < bound) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(empty_o && !busy_o), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    rst_n_i   = 1'b0;
    wr_en_i   = 1'b0;
    clr_ovf_i = 1'b0;
    wr_data_i = 8'h00;
    repeat (3) tick();
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_en", 32'(uart_tx_en_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    rst_n_i = 1'b1;
    tick();

    // 1: reset mid-frame with bytes queued
    sb.push_back(8'hC1);
    wr(8'hC1);
    wr(8'hC2);
    wr(8'hC3);
    wr(8'hC4);
    repeat (5) tick();
    check("t1_level_pre", 32'(level_o), 32'd3);
    check("t1_busy_pre", 32'(busy_o), 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check("t1_async_level", 32'(level_o), 32'd0);
    check("t1_async_busy", 32'(busy_o), 32'd0);
    check("t1_async_data", 32'(uart_tx_data_o), 32'd0);
    tick();
    rst_n_i = 1'b1;
    tick();
    check("t1_empty", 32'(empty_o), 32'd1);
    check("t1_en", 32'(uart_tx_en_o), 32'd0);
    base = en_cnt;
    repeat (2 * F) tick();
    check("t1_no_en", 32'(en_cnt - base), 32'd0);
    check("t1_busy", 32'(busy_o), 32'd0);

    // 2: single byte latency and frame length
    sb.push_back(8'hA5);
    wr(8'hA5);
    check("t2_en_e0", 32'(uart_tx_en_o), 32'd0);
    tick();
    check("t2_en_e1", 32'(uart_tx_en_o), 32'd1);
    check("t2_data", 32'(uart_tx_data_o), 32'hA5);
    n = 0;
    while (busy_o && n < 3 * F) begin
      n++;
      tick();
    end
    check("t2_busy_cycles", 32'(n), 32'(F));
    check("t2_data_hold", 32'(uart_tx_data_o), 32'hA5);

    // 3: burst of four, spacing F+1
    base = en_cyc.size();
    for (int i = 1; i <= 4; i++) begin
      sb.push_back(8'(i));
      wr(8'(i));
    end
    n = 0;
    while (en_cyc.size() < base + 4 && n < 8 * F) begin
      tick();
      n++;
    end
    check("t3_pulses", 32'(en_cyc.size() - base), 32'd4);
    if (en_cyc.size() >= base + 4) begin
      for (int k = 1; k < 4; k++) begin
        check("t3_spacing", 32'(en_cyc[base+k] - en_cyc[base+k-1]), 32'(F + 1));
      end
    end
    wait_drain("t3", 8 * (F + 2));

    // 4: overfill during WAIT, then clear overflow
    sb.push_back(8'h20);
    wr(8'h20);
    tick();
    tick();
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i < DEPTH) sb.push_back(8'(8'h30 + i));
      wr(8'(8'h30 + i));
    end
    check("t4_level", 32'(level_o), 32'(DEPTH));
    check("t4_full", 32'(full_o), 32'd1);
    check("t4_ovf", 32'(overflow_o), 32'd1);
    wr_data_i = 8'hFF;
    wr_en_i   = 1'b1;
    clr_ovf_i = 1'b1;
    tick();
    wr_en_i   = 1'b0;
    clr_ovf_i = 1'b0;
    check("t4_set_wins", 32'(overflow_o), 32'd1);
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    check("t4_clr", 32'(overflow_o), 32'd0);
    wait_drain("t4", 25 * (F + 2));

    // 5: push and pop together at count 1
    base = en_cyc.size();
    sb.push_back(8'h33);
    sb.push_back(8'h5A);
    wr(8'h33);
    wr(8'h5A);
    check("t5_level", 32'(level_o), 32'd1);
    wait_drain("t5", 4 * (F + 2));
    check("t5_pulses", 32'(en_cyc.size() - base), 32'd2);
    if (en_cyc.size() >= base + 2) begin
      check("t5_next_frame", 32'(en_cyc[base+1] - en_cyc[base]), 32'(F + 1));
    end

    // 6: full FIFO, push and pop in the same IDLE cycle
    sb.push_back(8'h60);
    wr(8'h60);
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(8'(8'h70 + i));
      wr(8'(8'h70 + i));
    end
    check("t6_full", 32'(full_o), 32'd1);
    n = 0;
    while (busy_o && n < 3 * F) begin
      tick();
      n++;
    end
    check("t6_idle_full", 32'({busy_o, full_o}), 32'b01);
    wr(8'hEE);
    check("t6_ovf", 32'(overflow_o), 32'd1);
    check("t6_level", 32'(level_o), 32'(DEPTH - 1));
    clr_ovf_i = 1'b1;
    tick();
    clr_ovf_i = 1'b0;
    wait_drain("t6", 25 * (F + 2));

    // Pointer wrap: 40 sequential bytes paced by full_o
    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (full_o && n < 3 * F) begin
        tick();
        n++;
      end
      sb.push_back(8'(i));
      wr(8'(i));
    end
    wait_drain("t6_wrap", 50 * (F + 2));
    check("t6_wrap_ovf", 32'(overflow_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
